id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID->EX boundary register of the 5-stage pipeline. Captures decode-stage payload (PC+4, rs/rt data,
//  sign-extended 16->32 immediate, sign-extended 5->32 shift amount, rt/rd indices, control word)
//  and presents it to EX. Implemented as a 2-entry skid buffer with valid/ready handshakes on both
//  sides, so EX back-pressure never creates a combinational ready path into ID. Branch flush from EX.
// PARAMETERS
//  DATA_W  32  width of PC+4, operand, immediate and shamt fields
//  CTRL_W  12  width of the opaque control word produced by the controller
// PORTS
//  Clk          in   1       clock, rising edge
//  Rst          in   1       asynchronous, active-low reset
//  flush        in   1       synchronous squash of all held and incoming entries
//  id_valid     in   1       ID payload valid
//  id_ready     out  1       buffer can accept (registered)
//  id_pc4       in   DATA_W  PC+4
//  id_rs_data   in   DATA_W  register-file read port A
//  id_rt_data   in   DATA_W  register-file read port B
//  id_imm32     in   DATA_W  sign-extended immediate
//  id_shamt32   in   DATA_W  sign-extended shift amount
//  id_rt        in   5       rt index
//  id_rd        in   5       rd index
//  id_ctrl      in   CTRL_W  control word
//  ex_valid     out  1       head entry valid
//  ex_ready     in   1       EX consumes head this cycle
//  ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_shamt32  out  DATA_W  head payload
//  ex_rt, ex_rd out  5 ; ex_ctrl out CTRL_W  head payload
// BEHAVIOUR
//  - Reset (Rst=0, async): state EMPTY, ex_valid=0, id_ready=1, every ex_* payload output = 0.
//  - Push = id_valid & id_ready; pop = ex_valid & ex_ready. Payload stored bit-exact, no arithmetic.
//  - FSM on occupancy: EMPTY, ONE, TWO.
//    EMPTY: push -> ONE (entry visible on ex_* next cycle; latency 1 clk).
//    ONE:   push&!pop -> TWO; pop&!push -> EMPTY; push&pop -> ONE (new entry becomes head).
//    TWO:   pop -> ONE (skid entry moves to head); push impossible (id_ready=0).
//  - id_ready registered: 1 in EMPTY/ONE, 0 in TWO; drops the cycle after entering TWO.
//  - ex_* outputs driven from head register only; order strictly FIFO.
//  - ex_valid=0 => ex_ctrl forced to 0 (bubble: no reg write, no mem access); other fields hold.
//  - flush: highest priority. Next state EMPTY, ex_valid=0, id_ready=1, same-cycle push discarded,
//    same-cycle pop still counts as consumed by EX. Flush in EMPTY is a no-op.
//  - ex_valid stable while ex_ready=0: payload must not change until popped or flushed.
//  - Reset asserted mid-transfer: entries discarded immediately, outputs to reset values.
// CONFIGURATION
//  IDEX_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
//    stall_cnt +1 each cycle id_valid & !id_ready; flush_cnt +1 each cycle flush & state!=EMPTY.
//    Both saturate at 16'hFFFF, reset to 0 by Rst, unaffected by flush.
//  Not defined: ports and counter logic absent; all other behaviour identical.
// TESTING
//  1 Reset release, id_valid=1, imm32=32'hFFFF_FFF0, ex_ready=1 -> ex_valid=1 next clk, ex_imm32=FFFF_FFF0.
//  2 ex_ready=0, push A,B -> TWO, id_ready=0; C held on ID; ex_ready=1 -> A, B, C popped in order.
//  3 Streaming 100 entries, ex_ready=1 every cycle -> one pop per clk, id_ready never 0.
//  4 State TWO, flush=1 with id_valid=1 -> next clk ex_valid=0, ex_ctrl=0, id_ready=1, nothing emitted.
//  5 Rst=0 asynchronously while ex_valid=1 -> ex_valid and all ex_* = 0 before next clock edge.
//  6 IDEX_PERF_CNT_EN: hold ex_ready=0, id_valid=1 for 70000 clks -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID->EX boundary register: 2-entry skid buffer with valid/ready on both sides.
// Optional perf counters (stall_cnt, flush_cnt) enabled by IDEX_PERF_CNT_EN.
module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm32,
  input  logic [DATA_W-1:0] id_shamt32,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm32,
  output logic [DATA_W-1:0] ex_shamt32,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm32;
    logic [DATA_W-1:0] shamt32;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_n;
  id_ex_t head, skid, din;
  logic   push, pop;
  logic   ld_in, ld_skid, mv_skid;

  assign din = '{
    pc4:     id_pc4,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm32:   id_imm32,
    shamt32: id_shamt32,
    rt:      id_rt,
    rd:      id_rd,
    ctrl:    id_ctrl
  };

  assign ex_valid = (state != EMPTY);
  assign push     = id_valid & id_ready;
  assign pop      = ex_valid & ex_ready;

  always_comb begin
    state_n = state;
    ld_in   = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_n = ONE;
          ld_in   = 1'b1;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            state_n = TWO;
            ld_skid = 1'b1;
          end
          2'b01: state_n = EMPTY;
          2'b11: ld_in = 1'b1;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          state_n = ONE;
          mv_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
    // flush squashes everything; head payload is left as-is
    if (flush) begin
      state_n = EMPTY;
      ld_in   = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= EMPTY;
      id_ready <= 1'b1;
      head     <= '0;
      skid     <= '0;
    end else begin
      state    <= state_n;
      id_ready <= (state_n != TWO);
      if (ld_in)
        head <= din;
      else if (mv_skid)
        head <= skid;
      if (ld_skid)
        skid <= din;
    end
  end

  assign ex_pc4     = head.pc4;
  assign ex_rs_data = head.rs_data;
  assign ex_rt_data = head.rt_data;
  assign ex_imm32   = head.imm32;
  assign ex_shamt32 = head.shamt32;
  assign ex_rt      = head.rt;
  assign ex_rd      = head.rd;
  assign ex_ctrl    = ex_valid ? head.ctrl : '0;

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && !id_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && state != EMPTY && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: vector table plus hand sequences.
// Counter checks run only when IDEX_PERF_CNT_EN is defined.
module tb_id_ex_pipeline_reg;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm32, id_shamt32;
  logic [4:0]  id_rt, id_rd;
  logic [11:0] id_ctrl;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm32, ex_shamt32;
  logic [4:0]  ex_rt, ex_rd;
  logic [11:0] ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  id_ex_pipeline_reg #(.DATA_W(32), .CTRL_W(12)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc4     (id_pc4),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm32   (id_imm32),
    .id_shamt32 (id_shamt32),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_ctrl    (id_ctrl),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_pc4     (ex_pc4),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm32   (ex_imm32),
    .ex_shamt32 (ex_shamt32),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [31:0] sh;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } pay_t;

  typedef struct {
    logic       v;
    logic       r;
    logic       f;
    logic [7:0] tag;
    logic       ev;
    logic       erdy;
    logic [7:0] etag;
  } vec_t;

  // each tag maps to a distinct payload; ctrl is never zero
  function automatic pay_t mk(input logic [7:0] t);
    pay_t p;
    p.pc4  = 32'h0040_0000 + {22'd0, t, 2'b00};
    p.rs   = {24'hA5A5A5, t};
    p.rt_d = {t, 24'h5A5A5A};
    p.imm  = {{24{t[7]}}, t};
    p.sh   = {{27{t[4]}}, t[4:0]};
    p.rt   = t[4:0];
    p.rd   = ~t[4:0];
    p.ctrl = {4'h9, t};
    return p;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic r,
                        input logic f, input logic [7:0] t);
    pay_t p;
    p          = mk(t);
    id_valid   = v;
    ex_ready   = r;
    flush      = f;
    id_pc4     = p.pc4;
    id_rs_data = p.rs;
    id_rt_data = p.rt_d;
    id_imm32   = p.imm;
    id_shamt32 = p.sh;
    id_rt      = p.rt;
    id_rd      = p.rd;
    id_ctrl    = p.ctrl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic ev,
                     input logic erdy, input logic [7:0] et);
    pay_t p;
    p = mk(et);
    cmp({nm, ".valid"}, idx, 64'(ex_valid), 64'(ev));
    cmp({nm, ".ready"}, idx, 64'(id_ready), 64'(erdy));
    if (ev) begin
      cmp({nm, ".pc4"}, idx, 64'(ex_pc4), 64'(p.pc4));
      cmp({nm, ".rs"}, idx, 64'(ex_rs_data), 64'(p.rs));
      cmp({nm, ".rtd"}, idx, 64'(ex_rt_data), 64'(p.rt_d));
      cmp({nm, ".imm"}, idx, 64'(ex_imm32), 64'(p.imm));
      cmp({nm, ".sh"}, idx, 64'(ex_shamt32), 64'(p.sh));
      cmp({nm, ".rt"}, idx, 64'(ex_rt), 64'(p.rt));
      cmp({nm, ".rd"}, idx, 64'(ex_rd), 64'(p.rd));
      cmp({nm, ".ctrl"}, idx, 64'(ex_ctrl), 64'(p.ctrl));
    end else begin
      cmp({nm, ".bubble_ctrl"}, idx, 64'(ex_ctrl), 64'd0);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    cmp({nm, ".valid"}, 0, 64'(ex_valid), 64'd0);
    cmp({nm, ".ready"}, 0, 64'(id_ready), 64'd1);
    cmp({nm, ".pc4"}, 0, 64'(ex_pc4), 64'd0);
    cmp({nm, ".rs"}, 0, 64'(ex_rs_data), 64'd0);
    cmp({nm, ".rtd"}, 0, 64'(ex_rt_data), 64'd0);
    cmp({nm, ".imm"}, 0, 64'(ex_imm32), 64'd0);
    cmp({nm, ".sh"}, 0, 64'(ex_shamt32), 64'd0);
    cmp({nm, ".rt"}, 0, 64'(ex_rt), 64'd0);
    cmp({nm, ".rd"}, 0, 64'(ex_rd), 64'd0);
    cmp({nm, ".ctrl"}, 0, 64'(ex_ctrl), 64'd0);
  endtask

  vec_t vt[16];

  initial begin
    // v r f tag | ev erdy etag
    vt[0]  = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b1, 1'b1, 8'd1};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 1'b1, 8'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b1, 1'b1, 8'd2};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'd3,  1'b1, 1'b0, 8'd2};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b1, 1'b0, 8'd2};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 8'd4,  1'b1, 1'b1, 8'd3};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 8'd4,  1'b1, 1'b1, 8'd4};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 8'd5,  1'b1, 1'b1, 8'd5};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 8'd5};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 8'd6,  1'b1, 1'b0, 8'd5};
    vt[10] = '{1'b1, 1'b0, 1'b1, 8'd7,  1'b0, 1'b1, 8'd0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 8'd0,  1'b0, 1'b1, 8'd0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 8'd8,  1'b0, 1'b1, 8'd0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 8'd9,  1'b1, 1'b1, 8'd9};
    vt[14] = '{1'b0, 1'b1, 1'b1, 8'd0,  1'b0, 1'b1, 8'd0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 8'd10, 1'b1, 1'b1, 8'd10};

    do_reset();
    #1;
    chk_zero("reset");

    // first entry visible one clock after the push
    set_in(1'b1, 1'b1, 1'b0, 8'd1);
    id_imm32 = 32'hFFFF_FFF0;
    tick();
    cmp("lat1.valid", 0, 64'(ex_valid), 64'd1);
    cmp("lat1.imm", 0, 64'(ex_imm32), 64'hFFFF_FFF0);
    set_in(1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    cmp("lat1.drain", 0, 64'(ex_valid), 64'd0);

    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].v, vt[i].r, vt[i].f, vt[i].tag);
      tick();
      chk("vec", i, vt[i].ev, vt[i].erdy, vt[i].etag);
    end

    // streaming: state ONE, push and pop every cycle
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 8'(100 + i));
      tick();
      chk("stream", i, 1'b1, 1'b1, 8'(100 + i));
    end
    set_in(1'b0, 1'b1, 1'b0, 8'd0);
    tick();
    chk("stream_end", 0, 1'b0, 1'b1, 8'd0);

    // async reset while holding two entries
    set_in(1'b1, 1'b0, 1'b0, 8'd20);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 8'd21);
    tick();
    chk("pre_rst", 0, 1'b1, 1'b0, 8'd20);
    #3;
    Rst = 1'b0;
    #1;
    chk_zero("async_rst");
    set_in(1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge Clk);
    Rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 8'd22);
    tick();
    chk("post_rst", 0, 1'b1, 1'b1, 8'd22);

`ifdef IDEX_PERF_CNT_EN
    do_reset();
    #1;
    cmp("stall_rst", 0, 64'(stall_cnt), 64'd0);
    cmp("flush_rst", 0, 64'(flush_cnt), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 8'd30);
    repeat (70000) @(posedge Clk);
    #1;
    cmp("stall_sat", 0, 64'(stall_cnt), 64'hFFFF);
    cmp("flush_idle", 0, 64'(flush_cnt), 64'd0);
    set_in(1'b1, 1'b0, 1'b1, 8'd31);
    tick();
    cmp("flush_cnt", 0, 64'(flush_cnt), 64'd1);
    cmp("stall_hold", 0, 64'(stall_cnt), 64'hFFFF);
    chk("perf_flush", 0, 1'b0, 1'b1, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
